// File: rtl/wishbone_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wishbone_arbiter
//  Purpose  : Two-master (instruction fetch / LSU) to one-slave Wishbone
//             arbiter with round-robin tie-break, one idle turnaround cycle
//             between tenures and an optional no-ACK timeout abort.
//  Revision : 1.0 - initial release
// ============================================================================
module wishbone_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  // master 0: instruction fetch
  input  logic                  i_M0_CYC,
  input  logic                  i_M0_STB,
  input  logic                  i_M0_WE,
  input  logic [3:0]            i_M0_SEL,
  input  logic [ADDR_WIDTH-1:0] i_M0_ADDR,
  input  logic [DATA_WIDTH-1:0] i_M0_DATA,
  output logic [DATA_WIDTH-1:0] o_M0_DATA,
  output logic                  o_M0_ACK,
  output logic                  o_M0_ERR,
  // master 1: load/store unit
  input  logic                  i_M1_CYC,
  input  logic                  i_M1_STB,
  input  logic                  i_M1_WE,
  input  logic [3:0]            i_M1_SEL,
  input  logic [ADDR_WIDTH-1:0] i_M1_ADDR,
  input  logic [DATA_WIDTH-1:0] i_M1_DATA,
  output logic [DATA_WIDTH-1:0] o_M1_DATA,
  output logic                  o_M1_ACK,
  output logic                  o_M1_ERR,
  // shared slave port
  output logic                  o_S_CYC,
  output logic                  o_S_STB,
  output logic                  o_S_WE,
  output logic [3:0]            o_S_SEL,
  output logic [ADDR_WIDTH-1:0] o_S_ADDR,
  output logic [DATA_WIDTH-1:0] o_S_DATA,
  input  logic [DATA_WIDTH-1:0] i_S_DATA,
  input  logic                  i_S_ACK,
  // current owner, one-hot
  output logic [1:0]            o_GNT
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GNT0 = 2'd1;
  localparam logic [1:0] GNT1 = 2'd2;

  // Timeout fires when the wait counter has already seen TIMEOUT-1 stalled
  // strobe cycles, i.e. in the TIMEOUT-th stalled cycle.
  localparam bit         TIMEOUT_EN   = (TIMEOUT > 0);
  localparam logic [15:0] TIMEOUT_LAST = TIMEOUT_EN ? 16'(TIMEOUT - 1) : 16'd0;

  logic [1:0]  state;
  logic [1:0]  next_state;
  logic        last;          // most recent owner: 0 = M0, 1 = M1
  logic [15:0] wait_count;
  logic        own_cyc;
  logic        own_stb;
  logic        timeout_hit;

  // Owner's bus qualifiers and the abort condition (ACK always wins)
  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    if (state == GNT0) begin
      own_cyc = i_M0_CYC;
      own_stb = i_M0_STB;
    end else if (state == GNT1) begin
      own_cyc = i_M1_CYC;
      own_stb = i_M1_STB;
    end
    timeout_hit = TIMEOUT_EN && own_cyc && own_stb && !i_S_ACK &&
                  (wait_count == TIMEOUT_LAST);
  end

  // State register, last-owner tracking and stalled-strobe counter
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state      <= IDLE;
      last       <= 1'b1;
      wait_count <= 16'd0;
    end else begin
      state <= next_state;
      if (state == IDLE && next_state == GNT0) begin
        last <= 1'b0;
      end else if (state == IDLE && next_state == GNT1) begin
        last <= 1'b1;
      end
      if (state == IDLE || i_S_ACK) begin
        wait_count <= 16'd0;
      end else if (o_S_STB && wait_count != 16'hFFFF) begin
        wait_count <= wait_count + 16'd1;
      end
    end
  end

  // Next-state: round-robin from IDLE, hold while owner keeps CYC
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (i_M0_CYC && i_M1_CYC) begin
          next_state = last ? GNT0 : GNT1;
        end else if (i_M0_CYC) begin
          next_state = GNT0;
        end else if (i_M1_CYC) begin
          next_state = GNT1;
        end
      end
      GNT0: begin
        if (!i_M0_CYC || timeout_hit) next_state = IDLE;
      end
      GNT1: begin
        if (!i_M1_CYC || timeout_hit) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Outputs: route owner onto slave bus, steer ACK/ERR back to owner only
  always_comb begin
    o_S_CYC  = 1'b0;
    o_S_STB  = 1'b0;
    o_S_WE   = 1'b0;
    o_S_SEL  = 4'd0;
    o_S_ADDR = '0;
    o_S_DATA = '0;
    o_M0_ACK = 1'b0;
    o_M1_ACK = 1'b0;
    o_M0_ERR = 1'b0;
    o_M1_ERR = 1'b0;
    o_GNT    = {state == GNT1, state == GNT0};
    case (state)
      GNT0: begin
        o_S_CYC  = i_M0_CYC;
        o_S_STB  = i_M0_STB;
        o_S_WE   = i_M0_WE;
        o_S_SEL  = i_M0_SEL;
        o_S_ADDR = i_M0_ADDR;
        o_S_DATA = i_M0_DATA;
        o_M0_ACK = i_S_ACK;
        o_M0_ERR = timeout_hit;
      end
      GNT1: begin
        o_S_CYC  = i_M1_CYC;
        o_S_STB  = i_M1_STB;
        o_S_WE   = i_M1_WE;
        o_S_SEL  = i_M1_SEL;
        o_S_ADDR = i_M1_ADDR;
        o_S_DATA = i_M1_DATA;
        o_M1_ACK = i_S_ACK;
        o_M1_ERR = timeout_hit;
      end
      default: ;
    endcase
    if (timeout_hit) begin
      o_S_CYC = 1'b0;
      o_S_STB = 1'b0;
    end
  end

  // Read data is broadcast; only the ACK tells a master it is meant for it
  assign o_M0_DATA = i_S_DATA;
  assign o_M1_DATA = i_S_DATA;

endmodule
`default_nettype wire

// File: tb/tb_wishbone_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wishbone_arbiter
//  Purpose  : Scenario bench for wishbone_arbiter (TIMEOUT = 4); expected
//             grants, slave transactions and error cycles are queued when
//             stimulus is applied and compared when the DUT responds.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wishbone_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 4;

  typedef struct packed {
    logic          we;
    logic [3:0]    sel;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [3:0]    m0_sel, m1_sel;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata;
  logic          m0_ack, m0_err, m1_ack, m1_err;
  logic          s_cyc, s_stb, s_we, s_ack;
  logic [3:0]    s_sel;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata, s_rdata;
  logic [1:0]    gnt;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [1:0]    exp_gnt_q[$];
  txn_t          exp_txn_q[$];
  int            exp_err_q[$];

  always #5 clk = ~clk;

  wishbone_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .i_CLK(clk), .i_RST(rst),
    .i_M0_CYC(m0_cyc), .i_M0_STB(m0_stb), .i_M0_WE(m0_we), .i_M0_SEL(m0_sel),
    .i_M0_ADDR(m0_addr), .i_M0_DATA(m0_wdata),
    .o_M0_DATA(m0_rdata), .o_M0_ACK(m0_ack), .o_M0_ERR(m0_err),
    .i_M1_CYC(m1_cyc), .i_M1_STB(m1_stb), .i_M1_WE(m1_we), .i_M1_SEL(m1_sel),
    .i_M1_ADDR(m1_addr), .i_M1_DATA(m1_wdata),
    .o_M1_DATA(m1_rdata), .o_M1_ACK(m1_ack), .o_M1_ERR(m1_err),
    .o_S_CYC(s_cyc), .o_S_STB(s_stb), .o_S_WE(s_we), .o_S_SEL(s_sel),
    .o_S_ADDR(s_addr), .o_S_DATA(s_wdata), .i_S_DATA(s_rdata), .i_S_ACK(s_ack),
    .o_GNT(gnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1;
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1;
    s_ack = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (gnt !== 2'b00) begin
      n_fail++; $display("FAIL reset_gnt: got %b expected 00", gnt);
    end
    n_tests++;
    if ({s_cyc, s_stb, s_we, s_sel, s_addr, s_wdata} !== {(3 + 4 + AW + DW){1'b0}}) begin
      n_fail++; $display("FAIL reset_slave_bus: got cyc=%b stb=%b we=%b sel=%b addr=%h data=%h expected all 0",
                         s_cyc, s_stb, s_we, s_sel, s_addr, s_wdata);
    end
    n_tests++;
    if ({m0_ack, m0_err, m1_ack, m1_err} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_master_resp: got %b expected 0000", {m0_ack, m0_err, m1_ack, m1_err});
    end
    m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0;
    m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0;
    s_ack = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_simultaneous();
    logic [1:0] e;
    m0_addr = 32'h0000_0100; m1_addr = 32'h0000_0200;
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    exp_gnt_q.push_back(2'b01);   // last resets to M1, so M0 wins the tie
    exp_gnt_q.push_back(2'b10);
    @(negedge clk);
    n_tests++;
    if ({gnt, s_cyc} !== 3'b000) begin
      n_fail++; $display("FAIL sim_latency: got gnt=%b s_cyc=%b expected 00/0 before edge", gnt, s_cyc);
    end
    tick();
    s_ack = 1'b1; s_rdata = 32'hCAFE_0001;
    @(negedge clk);
    e = exp_gnt_q.pop_front();
    n_tests++;
    if (gnt !== e || s_cyc !== 1'b1 || s_addr !== 32'h0000_0100) begin
      n_fail++; $display("FAIL sim_first_gnt: got gnt=%b cyc=%b addr=%h expected %b/1/00000100", gnt, s_cyc, s_addr, e);
    end
    n_tests++;
    if ({m0_ack, m1_ack} !== 2'b10 || m0_rdata !== 32'hCAFE_0001) begin
      n_fail++; $display("FAIL sim_ack: got m0_ack=%b m1_ack=%b rdata=%h expected 1/0/cafe0001", m0_ack, m1_ack, m0_rdata);
    end
    tick();
    s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    tick();
    @(negedge clk);
    n_tests++;
    if (gnt !== 2'b00) begin
      n_fail++; $display("FAIL sim_turnaround: got gnt=%b expected 00", gnt);
    end
    tick();
    @(negedge clk);
    e = exp_gnt_q.pop_front();
    n_tests++;
    if (gnt !== e || s_addr !== 32'h0000_0200) begin
      n_fail++; $display("FAIL sim_second_gnt: got gnt=%b addr=%h expected %b/00000200", gnt, s_addr, e);
    end
    tick();
    m1_cyc = 1'b0; m1_stb = 1'b0;
    tick(); tick();
  endtask

  task automatic test_fairness();
    logic [1:0] e, g, model_last;
    int n0, n1, wait_cnt;
    bit owner;
    n0 = 0; n1 = 0;
    model_last = 2'b10;
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    for (int i = 0; i < 8; i++) begin
      e = (model_last == 2'b01) ? 2'b10 : 2'b01;
      exp_gnt_q.push_back(e);
      model_last = e;
    end
    for (int i = 0; i < 8; i++) begin
      wait_cnt = 0;
      @(negedge clk);
      while (gnt == 2'b00 && wait_cnt < 10) begin
        @(negedge clk);
        wait_cnt++;
      end
      g = gnt;
      e = exp_gnt_q.pop_front();
      n_tests++;
      if (g !== e) begin
        n_fail++; $display("FAIL fair_gnt[%0d]: got %b expected %b", i, g, e);
      end
      if (g == 2'b00) break;
      owner = g[1];
      n_tests++;
      if (s_addr !== (owner ? m1_addr : m0_addr)) begin
        n_fail++; $display("FAIL fair_addr[%0d]: got %h expected %h", i, s_addr, owner ? m1_addr : m0_addr);
      end
      tick();
      s_ack = 1'b1;
      @(negedge clk);
      n_tests++;
      if ({m1_ack, m0_ack} !== g) begin
        n_fail++; $display("FAIL fair_ack[%0d]: got {m1,m0}=%b expected %b", i, {m1_ack, m0_ack}, g);
      end
      tick();
      s_ack = 1'b0;
      if (owner) begin m1_cyc = 1'b0; m1_stb = 1'b0; end
      else       begin m0_cyc = 1'b0; m0_stb = 1'b0; end
      tick();
      if (owner) begin m1_cyc = 1'b1; m1_stb = 1'b1; n1++; end
      else       begin m0_cyc = 1'b1; m0_stb = 1'b1; n0++; end
    end
    n_tests++;
    if (n0 !== 4 || n1 !== 4) begin
      n_fail++; $display("FAIL fair_balance: got m0=%0d m1=%0d expected 4/4", n0, n1);
    end
    m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    tick(); tick();
  endtask

  task automatic test_lone_write();
    txn_t t, got;
    int wait_cnt;
    m1_we = 1'b1; m1_sel = 4'b1100; m1_addr = 32'h0000_1002; m1_wdata = 32'hABCD_ABCD;
    m1_cyc = 1'b1; m1_stb = 1'b1;
    t = {1'b1, 4'b1100, 32'h0000_1002, 32'hABCD_ABCD};
    exp_txn_q.push_back(t);
    s_rdata = 32'h1234_5678;
    wait_cnt = 0;
    @(negedge clk);
    while (s_stb !== 1'b1 && wait_cnt < 10) begin
      @(negedge clk);
      wait_cnt++;
    end
    got = {s_we, s_sel, s_addr, s_wdata};
    t = exp_txn_q.pop_front();
    n_tests++;
    if (got !== t) begin
      n_fail++; $display("FAIL write_slave_bus: got %h expected %h", got, t);
    end
    n_tests++;
    if (gnt !== 2'b10 || {m0_ack, m1_ack} !== 2'b00) begin
      n_fail++; $display("FAIL write_gnt_noack: got gnt=%b acks=%b expected 10/00", gnt, {m0_ack, m1_ack});
    end
    n_tests++;
    if ({m0_rdata, m1_rdata} !== {32'h1234_5678, 32'h1234_5678}) begin
      n_fail++; $display("FAIL write_rdata_bcast: got m0=%h m1=%h expected 12345678", m0_rdata, m1_rdata);
    end
    tick();
    s_ack = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({m1_ack, m0_ack} !== 2'b10) begin
      n_fail++; $display("FAIL write_ack_pulse: got m1=%b m0=%b expected 1/0", m1_ack, m0_ack);
    end
    tick();
    s_ack = 1'b0;
    @(negedge clk);
    n_tests++;
    if (m1_ack !== 1'b0 || gnt !== 2'b10) begin
      n_fail++; $display("FAIL write_ack_drop: got ack=%b gnt=%b expected 0/10", m1_ack, gnt);
    end
    tick();
    m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0;
    tick(); tick();
  endtask

  task automatic test_timeout();
    int wait_cnt, cyc_n, err_cycle, e;
    m0_we = 1'b0; m0_cyc = 1'b1; m0_stb = 1'b1;
    exp_err_q.push_back(TO);   // ERR in the TO-th stalled strobe cycle
    wait_cnt = 0;
    @(negedge clk);
    while (gnt !== 2'b01 && wait_cnt < 10) begin
      @(negedge clk);
      wait_cnt++;
    end
    cyc_n = 1;
    while (m0_err !== 1'b1 && cyc_n < 10) begin
      @(negedge clk);
      cyc_n++;
    end
    err_cycle = (m0_err === 1'b1) ? cyc_n : -1;
    e = exp_err_q.pop_front();
    n_tests++;
    if (err_cycle !== e) begin
      n_fail++; $display("FAIL timeout_err_cycle: got %0d expected %0d", err_cycle, e);
    end
    n_tests++;
    if ({s_cyc, s_stb, m0_ack, m1_err} !== 4'b0000) begin
      n_fail++; $display("FAIL timeout_abort_bus: got cyc=%b stb=%b ack=%b m1_err=%b expected 0000",
                         s_cyc, s_stb, m0_ack, m1_err);
    end
    tick();
    m0_cyc = 1'b0; m0_stb = 1'b0;
    @(negedge clk);
    n_tests++;
    if (gnt !== 2'b00 || m0_err !== 1'b0) begin
      n_fail++; $display("FAIL timeout_idle: got gnt=%b err=%b expected 00/0", gnt, m0_err);
    end
    tick();
  endtask

  task automatic test_ack_boundary();
    m1_we = 1'b0; m1_cyc = 1'b1; m1_stb = 1'b1;
    tick();
    @(negedge clk);
    n_tests++;
    if (gnt !== 2'b10) begin
      n_fail++; $display("FAIL boundary_gnt: got %b expected 10", gnt);
    end
    tick(); tick(); tick();
    s_ack = 1'b1;             // 4th stalled cycle: the would-be timeout cycle
    @(negedge clk);
    n_tests++;
    if ({m1_ack, m1_err, s_cyc, s_stb} !== 4'b1011) begin
      n_fail++; $display("FAIL boundary_ack_wins: got ack=%b err=%b cyc=%b stb=%b expected 1/0/1/1",
                         m1_ack, m1_err, s_cyc, s_stb);
    end
    tick();
    s_ack = 1'b0;
    @(negedge clk);
    n_tests++;
    if (gnt !== 2'b10 || m1_err !== 1'b0) begin
      n_fail++; $display("FAIL boundary_hold: got gnt=%b err=%b expected 10/0", gnt, m1_err);
    end
    tick();
    m1_cyc = 1'b0; m1_stb = 1'b0;
    tick(); tick();
  endtask

  task automatic test_async_reset();
    logic [1:0] e;
    m1_cyc = 1'b1; m1_stb = 1'b1;
    tick();
    @(negedge clk);
    n_tests++;
    if (gnt !== 2'b10 || s_cyc !== 1'b1) begin
      n_fail++; $display("FAIL areset_pre: got gnt=%b cyc=%b expected 10/1", gnt, s_cyc);
    end
    #1 rst = 1'b1; s_ack = 1'b1;
    #1;
    n_tests++;
    if ({gnt, s_cyc, s_stb} !== 4'b0000) begin
      n_fail++; $display("FAIL areset_bus: got gnt=%b cyc=%b stb=%b expected 00/0/0", gnt, s_cyc, s_stb);
    end
    n_tests++;
    if ({m0_ack, m0_err, m1_ack, m1_err} !== 4'b0000) begin
      n_fail++; $display("FAIL areset_resp: got %b expected 0000", {m0_ack, m0_err, m1_ack, m1_err});
    end
    m0_cyc = 1'b1; m0_stb = 1'b1;
    exp_gnt_q.push_back(2'b01);
    #1 rst = 1'b0; s_ack = 1'b0;
    @(negedge clk);
    e = exp_gnt_q.pop_front();
    n_tests++;
    if (gnt !== e) begin
      n_fail++; $display("FAIL areset_restart: got %b expected %b", gnt, e);
    end
    tick();
    m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    tick(); tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; s_ack = 1'b0; s_rdata = 32'h0;
    m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; m0_sel = 4'hF;
    m0_addr = 32'h0000_0100; m0_wdata = 32'h1111_1111;
    m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0; m1_sel = 4'h3;
    m1_addr = 32'h0000_0200; m1_wdata = 32'h2222_2222;
    test_reset();
    test_simultaneous();
    test_fairness();
    test_lone_write();
    test_timeout();
    test_ack_boundary();
    test_async_reset();
    n_tests++;
    if (exp_gnt_q.size() + exp_txn_q.size() + exp_err_q.size() !== 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d leftover entries expected 0",
                         exp_gnt_q.size() + exp_txn_q.size() + exp_err_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wishbone_arbiter.md
WISHBONE_ARBITER -- requirements
Module: wishbone_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32: data bus width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32: address bus width.
REQ-003 The block SHALL have parameter TIMEOUT, default 255: cycles without ACK before abort; 0 disables the timeout.
REQ-004 The block SHALL have port i_CLK  in  1  single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port i_RST  in  1  reset; asynchronous, active-high.
REQ-006 The block SHALL have ports i_Mn_CYC, i_Mn_STB, i_Mn_WE (in, 1), i_Mn_SEL (in, 4), i_Mn_ADDR (in, ADDR_WIDTH), i_Mn_DATA (in, DATA_WIDTH), for n = 0 (instruction fetch) and n = 1 (LSU master).
REQ-007 The block SHALL have ports o_Mn_DATA (out, DATA_WIDTH), o_Mn_ACK (out, 1) and o_Mn_ERR (out, 1), for n = 0, 1.
REQ-008 The block SHALL have slave-side ports o_S_CYC, o_S_STB, o_S_WE (out, 1), o_S_SEL (out, 4), o_S_ADDR (out, ADDR_WIDTH), o_S_DATA (out, DATA_WIDTH), i_S_DATA (in, DATA_WIDTH) and i_S_ACK (in, 1).
REQ-009 The block SHALL have port o_GNT  out  2  one-hot current owner: bit0 = M0, bit1 = M1, 00 = idle.

Function
REQ-010 The FSM SHALL have states IDLE, GNT0 and GNT1, plus a 1-bit register last (most recent owner).
REQ-011 In IDLE with exactly one i_Mn_CYC high, the next state SHALL be GNTn.
REQ-012 In IDLE with both CYC high, the next state SHALL be GNT of the master not equal to last (round-robin).
REQ-013 On entry to GNTn, last SHALL be set to n.
REQ-014 Request-to-slave latency SHALL be exactly one cycle: o_S_CYC rises in the first cycle of GNTn.
REQ-015 In GNTn, o_S_CYC, o_S_STB, o_S_WE, o_S_SEL, o_S_ADDR and o_S_DATA SHALL be combinational copies of master n inputs.
REQ-016 In IDLE, all o_S_* outputs SHALL be 0.
REQ-017 o_M0_DATA and o_M1_DATA SHALL both equal i_S_DATA at all times.
REQ-018 o_Mn_ACK SHALL equal i_S_ACK AND (state == GNTn); the non-owner's ACK SHALL always be 0.
REQ-019 Ownership SHALL be held while i_Mn_CYC stays high, including across multiple STB/ACK beats.
REQ-020 In GNTn, when i_Mn_CYC is low, the next state SHALL be IDLE, giving one idle turnaround cycle before any new grant.
REQ-021 A 16-bit counter SHALL clear in IDLE and on any cycle with i_S_ACK high.
REQ-022 The counter SHALL increment in GNTn while o_S_STB is high and i_S_ACK is low, saturating at all-ones.
REQ-023 When TIMEOUT > 0 and the counter equals TIMEOUT-1 with no ACK, the block SHALL drive o_Mn_ERR high for one cycle.
REQ-024 In that abort cycle, o_S_CYC and o_S_STB SHALL be forced to 0 and the next state SHALL be IDLE.
REQ-025 An ACK in the same cycle as the timeout SHALL take precedence: ACK is delivered and no ERR is raised.
REQ-026 A request from the non-owner during GNTn SHALL be held pending and not granted until the path through IDLE completes.

Reset
REQ-027 i_RST high SHALL immediately force state IDLE, last = 1, counter = 0, o_GNT = 00, all o_S_* = 0, and o_Mn_ACK = o_Mn_ERR = 0.
REQ-028 Reset mid-transaction SHALL drop o_S_CYC in the same cycle; after release, arbitration SHALL restart from IDLE with M0 favoured on a tie.

Verification
REQ-029 Simultaneous first request: M0 and M1 CYC rise together after reset -> GNT0 next cycle (o_GNT = 01); M1 granted after M0 drops CYC plus one idle cycle.
REQ-030 Fairness: both masters request continuously for 8 transactions with slave ACK after 1 wait -> grants alternate 01, 10, 01, ..., with no starvation.
REQ-031 Lone LSU write: M1 writes SEL = 1100, ADDR = 0x1002, DATA = 0xABCDABCD -> slave sees identical values; o_M1_ACK pulses with i_S_ACK; o_M0_ACK stays 0.
REQ-032 Timeout: TIMEOUT = 4, slave never ACKs -> o_M0_ERR pulses in the 4th STB cycle, o_S_CYC drops that cycle, state returns to IDLE.
REQ-033 ACK on the boundary: i_S_ACK arrives exactly in the timeout cycle -> ACK is delivered and ERR stays 0.
REQ-034 Async reset mid-transfer: i_RST asserted between clock edges during GNT1 -> o_S_CYC = 0 and o_GNT = 00 before the next edge.
